// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin pop/push scheduler sharing one egress FIFO among four VC source FIFOs
module fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int QUANTUM    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              empty_in,
    input  logic [4*DATA_WIDTH-1:0] data_in,
    input  logic                    almost_full_dest,
    output logic [3:0]              pop_out,
    output logic                    push_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [1:0]              grant_id,
    output logic                    busy,
    output logic                    stall
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [3:0] QUANT = 4'(QUANTUM);

    state_t     state, state_next;
    logic [1:0] rr_ptr, rr_ptr_next;
    logic [1:0] grant_next;
    logic [3:0] burst_cnt, cnt_next;
    logic       pop_valid_q;
    logic [1:0] sel_q;

    logic [3:0] req;
    logic       can_pop;
    logic [1:0] search_start;
    logic [1:0] cand;
    logic       win_found;
    logic [1:0] win_idx;
    logic       releasing;
    logic       pop_any;
    logic [1:0] pop_idx;

    assign req     = ~empty_in;
    assign can_pop = enable & ~almost_full_dest;

    // A releasing burst searches from grant_id+1, so the current holder is considered last.
    always_comb begin
        search_start = (state == BURST) ? grant_id + 2'd1 : rr_ptr;
        win_found    = 1'b0;
        win_idx      = search_start;
        cand         = search_start;
        for (int k = 3; k >= 0; k--) begin
            cand = search_start + 2'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 2'd0;
            grant_id    <= 2'd0;
            burst_cnt   <= 4'd0;
            pop_valid_q <= 1'b0;
            sel_q       <= 2'd0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            grant_id    <= grant_next;
            burst_cnt   <= cnt_next;
            pop_valid_q <= pop_any;
            sel_q       <= pop_idx;
        end
    end

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        grant_next  = grant_id;
        cnt_next    = burst_cnt;
        releasing   = 1'b0;
        pop_any     = 1'b0;
        pop_idx     = grant_id;
        case (state)
            IDLE: begin
                if (can_pop && win_found) begin
                    pop_any    = 1'b1;
                    pop_idx    = win_idx;
                    grant_next = win_idx;
                    cnt_next   = 4'd1;
                    state_next = BURST;
                end
            end
            BURST: begin
                releasing = ~req[grant_id] | (burst_cnt >= QUANT);
                if (releasing) begin
                    rr_ptr_next = grant_id + 2'd1;
                    if (can_pop && win_found) begin
                        pop_any    = 1'b1;
                        pop_idx    = win_idx;
                        grant_next = win_idx;
                        cnt_next   = 4'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (can_pop) begin
                    pop_any  = 1'b1;
                    pop_idx  = grant_id;
                    cnt_next = burst_cnt + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are gated by reset so nothing escapes while the block is held in reset.
    always_comb begin
        pop_out = 4'b0000;
        if (pop_any && !reset) begin
            pop_out[pop_idx] = 1'b1;
        end
        push_out = pop_valid_q & ~reset;
        data_out = pop_valid_q ? data_in[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
        busy     = (state == BURST);
        stall    = ~reset & (|req) & ~(|pop_out);
    end

endmodule
